// File: rtl/alu_arbiter.sv
// Round-robin two-requester front end for the shared combinational ALU.
// Optional feature macro: ALU_ARB_DIVZERO_CHK_EN (divide/modulo by zero answered without the ALU).
module alu_arbiter #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned EXEC_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_res,
    output logic             rsp_err,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_res,
    output logic             busy
);
    localparam int unsigned      CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXEC_CYCLES - 1);
    localparam logic [2:0]       OP_UNDEF = 3'd7;
`ifdef ALU_ARB_DIVZERO_CHK_EN
    localparam logic [2:0]       OP_DIV   = 3'd2;
    localparam logic [2:0]       OP_MOD   = 3'd4;
`endif

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state, state_nxt;
    logic             prio, prio_nxt;
    logic             grant, grant_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       op_nxt;
    logic [WIDTH-1:0] a_nxt, b_nxt, res_nxt;
    logic             err_nxt;

    // Winner of the current IDLE cycle and its payload
    logic             sel;
    logic [2:0]       sel_op;
    logic [WIDTH-1:0] sel_a, sel_b;
    logic             div_zero;

    assign sel    = (req0_valid && req1_valid) ? prio : req1_valid;
    assign sel_op = sel ? req1_op : req0_op;
    assign sel_a  = sel ? req1_a  : req0_a;
    assign sel_b  = sel ? req1_b  : req0_b;
`ifdef ALU_ARB_DIVZERO_CHK_EN
    assign div_zero = ((sel_op == OP_DIV) || (sel_op == OP_MOD)) && (sel_b == '0);
`else
    assign div_zero = 1'b0;
`endif
    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            prio    <= 1'b0;
            grant   <= 1'b0;
            cnt     <= '0;
            alu_op  <= '0;
            alu_a   <= '0;
            alu_b   <= '0;
            rsp_res <= '0;
            rsp_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            prio    <= prio_nxt;
            grant   <= grant_nxt;
            cnt     <= cnt_nxt;
            alu_op  <= op_nxt;
            alu_a   <= a_nxt;
            alu_b   <= b_nxt;
            rsp_res <= res_nxt;
            rsp_err <= err_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        prio_nxt   = prio;
        grant_nxt  = grant;
        cnt_nxt    = cnt;
        op_nxt     = alu_op;
        a_nxt      = alu_a;
        b_nxt      = alu_b;
        res_nxt    = rsp_res;
        err_nxt    = rsp_err;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        unique case (state)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    req0_ready = !sel;
                    req1_ready = sel;
                    grant_nxt  = sel;
                    op_nxt     = sel_op;
                    a_nxt      = sel_a;
                    b_nxt      = sel_b;
                    cnt_nxt    = '0;
                    if (sel_op == OP_UNDEF) begin
                        state_nxt = RESP;
                        res_nxt   = '0;
                        err_nxt   = 1'b1;
                    end else if (div_zero) begin
                        state_nxt = RESP;
                        res_nxt   = {WIDTH{1'b1}};
                        err_nxt   = 1'b1;
                    end else begin
                        state_nxt = EXEC;
                    end
                end
            end
            EXEC: begin
                cnt_nxt = cnt + CNT_W'(1);
                if (cnt == CNT_LAST) begin
                    res_nxt   = alu_res;
                    err_nxt   = 1'b0;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp0_valid = !grant;
                rsp1_valid = grant;
                // Handshake completes; the other requester gets priority next
                if (grant ? rsp1_ready : rsp0_ready) begin
                    state_nxt = IDLE;
                    prio_nxt  = !grant;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized bench for alu_arbiter with a transaction-level reference model and an ALU stub.
module tb_alu_arbiter;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned EC    = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req0_valid, req0_ready, req1_valid, req1_ready;
    logic [2:0]       req0_op, req1_op, alu_op;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic             rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [WIDTH-1:0] rsp_res, alu_a, alu_b, alu_res;
    logic             rsp_err, busy;

    alu_arbiter #(.WIDTH(WIDTH), .EXEC_CYCLES(EC)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_res(rsp_res), .rsp_err(rsp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_res(alu_res),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behaviour of the shared ALU (unsigned view)
    function automatic logic [WIDTH-1:0] alu_fn(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return (b == 0) ? '0 : a / b;
            3'd3:    return a * b;
            3'd4:    return (b == 0) ? '0 : a % b;
            3'd5:    return (a < b) ? WIDTH'(1) : '0;
            3'd6:    return (a == b) ? WIDTH'(1) : '0;
            default: return '0;
        endcase
    endfunction

    always_comb alu_res = alu_fn(alu_op, alu_a, alu_b);

    // Requester-side pending transactions
    logic             p0, p1;
    logic [2:0]       p0_op, p1_op;
    logic [WIDTH-1:0] p0_a, p0_b, p1_a, p1_b;

    // Reference model state
    logic             m_out, m_prio, m_grant, e_err, gv, g;
    logic [2:0]       x_op;
    logic [WIDTH-1:0] x_a, x_b, e_res;
    int               cyc, acc, lat;

    function automatic logic [WIDTH-1:0] rnd_val(input bit allow_zero);
        if (allow_zero && ($urandom % 4 == 0)) return '0;
        if ($urandom % 3 == 0) return WIDTH'($urandom % 8);
        return WIDTH'($urandom);
    endfunction

    task automatic check_reset(input string tag);
        check({tag, "_req0_ready"}, req0_ready, 0);
        check({tag, "_req1_ready"}, req1_ready, 0);
        check({tag, "_rsp0_valid"}, rsp0_valid, 0);
        check({tag, "_rsp1_valid"}, rsp1_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_rsp_err"}, rsp_err, 0);
        check({tag, "_rsp_res"}, rsp_res, 0);
        check({tag, "_alu_a"}, alu_a, 0);
        check({tag, "_alu_b"}, alu_b, 0);
        check({tag, "_alu_op"}, alu_op, 0);
    endtask

    // mode 0: random traffic/backpressure, 1: constant contention, 2: drain pending only
    task automatic cycle(input int mode);
        logic err_path;
        @(posedge clk); #1;
        if (!p0 && (mode == 1 || (mode == 0 && ($urandom % 2 == 1)))) begin
            p0 = 1'b1;
            if (mode == 1) begin p0_op = 3'd3; p0_a = 6; p0_b = 7; end
            else begin p0_op = 3'($urandom % 8); p0_a = rnd_val(0); p0_b = rnd_val(1); end
        end
        if (!p1 && (mode == 1 || (mode == 0 && ($urandom % 2 == 1)))) begin
            p1 = 1'b1;
            if (mode == 1) begin p1_op = 3'd1; p1_a = 10; p1_b = 4; end
            else begin p1_op = 3'($urandom % 8); p1_a = rnd_val(0); p1_b = rnd_val(1); end
        end
        req0_valid = p0; req0_op = p0_op; req0_a = p0_a; req0_b = p0_b;
        req1_valid = p1; req1_op = p1_op; req1_a = p1_a; req1_b = p1_b;
        rsp0_ready = (mode != 0) ? 1'b1 : ($urandom % 3 == 0);
        rsp1_ready = (mode != 0) ? 1'b1 : ($urandom % 3 == 0);
        @(negedge clk);
        cyc++;
        check("busy", busy, m_out);
        if (!m_out) begin
            gv = p0 || p1;
            g  = (p0 && p1) ? m_prio : p1;
            check("req0_ready", req0_ready, gv && !g);
            check("req1_ready", req1_ready, gv && g);
            check("rsp0_valid_idle", rsp0_valid, 0);
            check("rsp1_valid_idle", rsp1_valid, 0);
            if (gv) begin
                m_out = 1'b1; m_grant = g; acc = cyc;
                x_op = g ? p1_op : p0_op;
                x_a  = g ? p1_a  : p0_a;
                x_b  = g ? p1_b  : p0_b;
                err_path = (x_op == 3'd7);
`ifdef ALU_ARB_DIVZERO_CHK_EN
                if ((x_op == 3'd2 || x_op == 3'd4) && x_b == 0) begin
                    err_path = 1'b1;
                    e_res = {WIDTH{1'b1}};
                end
`endif
                if (x_op == 3'd7) e_res = '0;
                else if (!err_path) e_res = alu_fn(x_op, x_a, x_b);
                e_err = err_path;
                lat = err_path ? 1 : EC + 1;
                if (g) p1 = 1'b0; else p0 = 1'b0;
            end
        end else begin
            check("req0_ready_busy", req0_ready, 0);
            check("req1_ready_busy", req1_ready, 0);
            check("alu_op", alu_op, x_op);
            check("alu_a", alu_a, x_a);
            check("alu_b", alu_b, x_b);
            check("rsp0_valid", rsp0_valid, (cyc >= acc + lat) && !m_grant);
            check("rsp1_valid", rsp1_valid, (cyc >= acc + lat) && m_grant);
            if (cyc >= acc + lat) begin
                check("rsp_res", rsp_res, e_res);
                check("rsp_err", rsp_err, e_err);
                if (m_grant ? rsp1_ready : rsp0_ready) begin
                    m_out  = 1'b0;
                    m_prio = !m_grant;
                end
            end
        end
    endtask

    initial begin
        req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
        req0_op = 0; req1_op = 0; req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
        p0 = 0; p1 = 0; p0_op = 0; p1_op = 0; p0_a = 0; p0_b = 0; p1_a = 0; p1_b = 0;
        m_out = 0; m_prio = 0; m_grant = 0; cyc = 0; acc = 0; lat = 1;
        x_op = 0; x_a = 0; x_b = 0; e_res = 0; e_err = 0;
        #3;
        check_reset("por");
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        repeat (40) cycle(1);
        repeat (20) cycle(2);

        // Reset during the second EXEC cycle
        @(posedge clk); #1;
        req0_valid = 1; req0_op = 3'd0; req0_a = 7; req0_b = 9;
        rsp0_ready = 0; rsp1_ready = 0;
        @(negedge clk);
        check("mid_accept", req0_ready, 1);
        @(posedge clk); #1;
        req0_valid = 0;
        @(posedge clk); #1;
        check("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check_reset("mid");
        #2;
        rst_n = 1'b1;
        m_out = 0; m_prio = 0; p0 = 0; p1 = 0;

        repeat (3000) cycle(0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester front end for the shared 32-bit combinational ALU (ops 0–6: add, sub, div, mul, mod, less-than, equal). Arbitrates round-robin between two independent requesters and latches the winning operands. Drives the ALU for a configurable number of settle cycles, captures the result and returns it to the winner over a valid/ready response channel. Sits between the decode/issue stages and the ALU instance inside the processor core.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width; must match the ALU.
- `EXEC_CYCLES`, 1, number of cycles the ALU inputs are held before the result is captured. Legal range is 1–15.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req0_valid` / `req1_valid` input 1: the requester presents an operation.
- `req0_ready` / `req1_ready` output 1: the arbiter accepts the operation; transfer occurs when valid && ready.
- `req0_op` / `req1_op` input 3: ALU opcode.
- `req0_a`, `req0_b` / `req1_a`, `req1_b` input WIDTH: operands.
- `rsp0_valid` / `rsp1_valid` output 1: the result is available for that requester.
- `rsp0_ready` / `rsp1_ready` input 1: the requester consumes the result.
- `rsp_res` output WIDTH: result, shared by both response channels.
- `rsp_err` output 1: error flag, valid alongside `rsp_res`.
- `alu_a`, `alu_b` output WIDTH: ALU operand inputs.
- `alu_op` output 3: ALU opcode input.
- `alu_res` input WIDTH: ALU result.
- `busy` output 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- Round-robin pointer `prio` (1 bit): the preferred requester. On reset `prio` is 0.
- **IDLE**
  - Grant selection: if only one requester is valid, that requester is granted. If both are valid, requester `prio` is granted.
  - `reqN_ready` is asserted combinationally for the granted requester only. Both ready signals are 0 when neither requester is valid.
  - On the transfer, the arbiter latches op, a, b and the grant index.
  - Next state:
    - op==7 (undefined): go to RESP with err=1, res=0.
    - Otherwise: go to EXEC with the cycle counter cleared.
- **EXEC**
  - `alu_a`/`alu_b`/`alu_op` are driven from the latched registers.
  - The counter increments each cycle.
  - In the cycle where counter==EXEC_CYCLES-1, `alu_res` is registered into `rsp_res`, err is set to 0, and the FSM goes to RESP.
- **RESP**
  - `rspN_valid` is high for the granted index only. `rsp_res` and `rsp_err` are held stable.
  - When `rspN_valid && rspN_ready`: go to IDLE and set `prio` to the other index. No request is accepted in that same cycle.
  - Without a handshake the FSM stays in RESP indefinitely.
- ALU inputs hold their last latched values outside EXEC; they are never changed except on request acceptance.
- Operands pass to the ALU unmodified. Signedness is the ALU's concern.
- Requests and responses are strictly one outstanding at a time.

## Timing
- Reset values: all `reqN_ready`, all `rspN_valid`, `busy`, `rsp_err` = 0; `rsp_res`, `alu_a`, `alu_b` = 0; `alu_op` = 0; state = IDLE; `prio` = 0.
- Latency: if a request is accepted in cycle T, EXEC occupies T+1 … T+EXEC_CYCLES and `rspN_valid` rises in cycle T+EXEC_CYCLES+1. With EXEC_CYCLES=1 the response appears 2 cycles after acceptance.
- Op 7 and the configured error path skip EXEC, so the response appears at T+1.
- Back-to-back throughput: the earliest next acceptance is the cycle after the response handshake. Minimum period is EXEC_CYCLES+2 cycles.
- Simultaneous requests: exactly one is granted. The loser keeps its valid high and its request is not dropped. The requester must hold its payload stable while valid && !ready.
- `rspN_ready` asserted while that channel's `rspN_valid` is low is ignored.
- Asynchronous reset in any state aborts the operation: no response is issued, all outputs take their reset values immediately, and `prio` returns to 0.

## Configuration
- `ALU_ARB_DIVZERO_CHK_EN`
  - When defined: an accepted op 2 (div) or op 4 (mod) with b==0 bypasses the ALU and goes directly to RESP with `rsp_err`=1 and `rsp_res`={WIDTH{1'b1}}. The ALU inputs still update to the latched values.
  - When undefined: these operations are issued to the ALU normally, `rsp_res` is whatever `alu_res` gives, and `rsp_err`=0. Only op 7 flags an error.

## Test plan
- **Single request:** EXEC_CYCLES=1; req0 op=0 a=5 b=3, valid at cycle 0 → `req0_ready`=1 in cycle 0, `rsp0_valid`=1 in cycle 2, `rsp_res`=8, `rsp_err`=0, `rsp1_valid` stays 0.
- **Contention and fairness:** both requesters valid continuously from reset (req0 op=3 a=6 b=7, req1 op=1 a=10 b=4) → grants alternate req0, req1, req0, req1; responses 42, 6, 42, 6; neither request is ever lost.
- **Backpressure:** `rsp0_ready` held low for 3 cycles after `rsp0_valid` rises → valid and `rsp_res` stay stable, `busy`=1, `req1_ready` stays 0 despite `req1_valid`; ready pulses high → back to IDLE on the next cycle.
- **Undefined op:** op=7 → `rsp_err`=1 and `rsp_res`=0 at acceptance+1; the FSM never enters EXEC.
- **Divide by zero:** op=2 a=10 b=0 → with `ALU_ARB_DIVZERO_CHK_EN`: `rsp_err`=1, `rsp_res`=32'hFFFF_FFFF at acceptance+1. Without it: the response arrives at acceptance+EXEC_CYCLES+1 with `rsp_err`=0.
- **Reset mid-operation:** EXEC_CYCLES=4; `rst_n` pulled low in the 2nd EXEC cycle → all outputs go to reset values immediately; after release, no stale response appears and a new req1 is granted normally.
